// File: rtl/maze_job_sched_if.sv
// Signal bundle between the MAZE job scheduler, its clients and the shared solver.
// The slave modport is the scheduler's view; master is the environment driving it.
interface maze_job_sched_if #(
  parameter int NUM_REQ = 2,
  parameter int ID_W    = 1
);
  logic [NUM_REQ-1:0] req;
  logic [NUM_REQ-1:0] gnt;
  logic [NUM_REQ-1:0] cl_in_valid;
  logic [NUM_REQ-1:0] cl_in;
  logic               sol_rst_n;
  logic               sol_in_valid;
  logic               sol_in;
  logic               sol_out_valid;
  logic [1:0]         sol_out;
  logic               rsp_valid;
  logic [1:0]         rsp_dir;
  logic [ID_W-1:0]    rsp_id;
  logic               rsp_last;
  logic               rsp_err;
  logic               busy;

  modport slave (
    input  req, cl_in_valid, cl_in, sol_out_valid, sol_out,
    output gnt, sol_rst_n, sol_in_valid, sol_in,
           rsp_valid, rsp_dir, rsp_id, rsp_last, rsp_err, busy
  );

  modport master (
    output req, cl_in_valid, cl_in, sol_out_valid, sol_out,
    input  gnt, sol_rst_n, sol_in_valid, sol_in,
           rsp_valid, rsp_dir, rsp_id, rsp_last, rsp_err, busy
  );
endinterface

// File: rtl/maze_job_sched.sv
// Round-robin front end sharing one MAZE solver between NUM_REQ clients, with
// gap / timeout / over-long-burst detection and a solver-local reset pulse.
//
// state   | meaning
// IDLE    | arbitrate over req, grant winner
// FEED    | forward granted client's maze stream to the solver
// WAIT    | wait for first solver beat, bounded by TIMEOUT
// DRAIN   | pass solver beats through a one-entry stage to rsp_*
// RECOVER | hold sol_rst_n low for RECOVER_CYCLES
module maze_job_sched #(
  parameter int NUM_REQ        = 2,
  parameter int ID_W           = 1,
  parameter int MAZE_CELLS     = 289,
  parameter int TIMEOUT        = 4096,
  parameter int MAX_BEATS      = 150,
  parameter int RECOVER_CYCLES = 2
) (
  input  logic            clk,
  input  logic            rst_n,
  maze_job_sched_if.slave bus
);
  localparam int CNT_MAX = (MAZE_CELLS > TIMEOUT) ? MAZE_CELLS : TIMEOUT;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam int BEAT_W  = $clog2(MAX_BEATS + 1);

  typedef enum logic [2:0] {IDLE, FEED, WAIT, DRAIN, RECOVER} state_e;

  state_e             state_q, state_d;
  logic [ID_W-1:0]    ptr_q, ptr_d, job_id_q, job_id_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [BEAT_W-1:0]  beat_q, beat_d;
  logic [1:0]         hold_q, hold_d;
  logic [NUM_REQ-1:0] gnt_q, gnt_d;
  logic               sol_rst_n_q, sol_rst_n_d;
  logic               sol_in_valid_q, sol_in_valid_d;
  logic               sol_in_q, sol_in_d;
  logic               rsp_valid_q, rsp_valid_d;
  logic [1:0]         rsp_dir_q, rsp_dir_d;
  logic [ID_W-1:0]    rsp_id_q, rsp_id_d;
  logic               rsp_last_q, rsp_last_d;
  logic               rsp_err_q, rsp_err_d;
  logic               busy_q, busy_d;

  logic [2*NUM_REQ-1:0] req_rot_full;
  logic [NUM_REQ-1:0]   req_rot;
  logic                 win_found;
  int                   win_sum;
  logic [ID_W-1:0]      win_idx;
  logic                 cl_v, cl_b, abort;

  // Rotating the doubled request vector puts client ptr+1 at bit 0.
  always_comb begin
    req_rot_full = {bus.req, bus.req} >> (ptr_q + ID_W'(1));
    req_rot      = req_rot_full[NUM_REQ-1:0];
    win_found    = 1'b0;
    win_sum      = 0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (!win_found && req_rot[i]) begin
        win_found = 1'b1;
        win_sum   = int'(ptr_q) + 1 + i;
      end
    end
    win_idx = ID_W'(win_sum % NUM_REQ);
  end

  assign cl_v = bus.cl_in_valid[job_id_q];
  assign cl_b = bus.cl_in[job_id_q];

  always_comb begin
    state_d        = state_q;
    ptr_d          = ptr_q;
    job_id_d       = job_id_q;
    cnt_d          = cnt_q;
    beat_d         = beat_q;
    hold_d         = hold_q;
    gnt_d          = gnt_q;
    sol_rst_n_d    = 1'b1;
    sol_in_valid_d = 1'b0;
    sol_in_d       = 1'b0;
    rsp_valid_d    = 1'b0;
    rsp_dir_d      = 2'd0;
    rsp_id_d       = job_id_q;
    rsp_last_d     = 1'b0;
    rsp_err_d      = 1'b0;
    abort          = 1'b0;
    case (state_q)
      IDLE: begin
        gnt_d = '0;
        if (win_found) begin
          gnt_d    = NUM_REQ'(1) << win_idx;
          job_id_d = win_idx;
          cnt_d    = '0;
          state_d  = FEED;
        end
      end
      FEED: begin
        if (cl_v) begin
          sol_in_valid_d = 1'b1;
          sol_in_d       = cl_b;
          cnt_d          = cnt_q + CNT_W'(1);
          if (cnt_q == CNT_W'(MAZE_CELLS - 1)) begin
            gnt_d   = '0;
            cnt_d   = '0;
            state_d = WAIT;
          end
        end else if (cnt_q != '0) begin
          abort = 1'b1;
        end
      end
      WAIT: begin
        if (bus.sol_out_valid) begin
          hold_d  = bus.sol_out;
          beat_d  = BEAT_W'(1);
          state_d = DRAIN;
        end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
          abort = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      DRAIN: begin
        if (bus.sol_out_valid && beat_q == BEAT_W'(MAX_BEATS)) begin
          abort = 1'b1;
        end else begin
          // The held beat is last exactly when no successor is arriving now.
          rsp_valid_d = 1'b1;
          rsp_dir_d   = hold_q;
          rsp_last_d  = !bus.sol_out_valid;
          if (bus.sol_out_valid) begin
            hold_d = bus.sol_out;
            beat_d = beat_q + BEAT_W'(1);
          end else begin
            ptr_d   = job_id_q;
            state_d = IDLE;
          end
        end
      end
      RECOVER: begin
        sol_rst_n_d = 1'b0;
        if (cnt_q == CNT_W'(RECOVER_CYCLES - 1)) begin
          sol_rst_n_d = 1'b1;
          ptr_d       = job_id_q;
          state_d     = IDLE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
    if (abort) begin
      gnt_d          = '0;
      sol_in_valid_d = 1'b0;
      rsp_valid_d    = 1'b1;
      rsp_dir_d      = 2'd0;
      rsp_last_d     = 1'b1;
      rsp_err_d      = 1'b1;
      sol_rst_n_d    = 1'b0;
      cnt_d          = '0;
      state_d        = RECOVER;
    end
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= IDLE;
      ptr_q          <= ID_W'(NUM_REQ - 1);
      job_id_q       <= '0;
      cnt_q          <= '0;
      beat_q         <= '0;
      hold_q         <= 2'd0;
      gnt_q          <= '0;
      sol_rst_n_q    <= 1'b0;
      sol_in_valid_q <= 1'b0;
      sol_in_q       <= 1'b0;
      rsp_valid_q    <= 1'b0;
      rsp_dir_q      <= 2'd0;
      rsp_id_q       <= '0;
      rsp_last_q     <= 1'b0;
      rsp_err_q      <= 1'b0;
      busy_q         <= 1'b0;
    end else begin
      state_q        <= state_d;
      ptr_q          <= ptr_d;
      job_id_q       <= job_id_d;
      cnt_q          <= cnt_d;
      beat_q         <= beat_d;
      hold_q         <= hold_d;
      gnt_q          <= gnt_d;
      sol_rst_n_q    <= sol_rst_n_d;
      sol_in_valid_q <= sol_in_valid_d;
      sol_in_q       <= sol_in_d;
      rsp_valid_q    <= rsp_valid_d;
      rsp_dir_q      <= rsp_dir_d;
      rsp_id_q       <= rsp_id_d;
      rsp_last_q     <= rsp_last_d;
      rsp_err_q      <= rsp_err_d;
      busy_q         <= busy_d;
    end
  end

  assign bus.gnt          = gnt_q;
  assign bus.sol_rst_n    = sol_rst_n_q;
  assign bus.sol_in_valid = sol_in_valid_q;
  assign bus.sol_in       = sol_in_q;
  assign bus.rsp_valid    = rsp_valid_q;
  assign bus.rsp_dir      = rsp_dir_q;
  assign bus.rsp_id       = rsp_id_q;
  assign bus.rsp_last     = rsp_last_q;
  assign bus.rsp_err      = rsp_err_q;
  assign bus.busy         = busy_q;
endmodule

// File: tb/tb_maze_job_sched.sv
// Directed bench for maze_job_sched: two clients, a behavioural solver stub that
// answers each 289-bit stream with a configurable burst (16 D then R beats).
module tb_maze_job_sched;
  localparam int NUM_REQ    = 2;
  localparam int ID_W       = 1;
  localparam int MAZE_CELLS = 289;
  localparam int TIMEOUT    = 4096;
  localparam int MAX_BEATS  = 150;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  maze_job_sched_if #(.NUM_REQ(NUM_REQ), .ID_W(ID_W)) bus ();

  maze_job_sched #(
    .NUM_REQ(NUM_REQ), .ID_W(ID_W), .MAZE_CELLS(MAZE_CELLS),
    .TIMEOUT(TIMEOUT), .MAX_BEATS(MAX_BEATS), .RECOVER_CYCLES(2)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic logic mbit(input int k);
    return k[0] ^ k[3];
  endfunction

  function automatic logic [1:0] exp_dir(input int i);
    return (i < 16) ? 2'd1 : 2'd0;
  endfunction

  // Solver stub: counts fed bits, then after a short delay emits st_beats beats.
  int st_beats = 32;
  int st_bits, st_cd, st_left, st_idx;
  initial begin
    bus.sol_out_valid = 1'b0;
    bus.sol_out       = 2'd0;
    st_bits = 0; st_cd = 0; st_left = 0; st_idx = 0;
    forever begin
      @(negedge clk);
      bus.sol_out_valid = 1'b0;
      bus.sol_out       = 2'd0;
      if (!rst_n || !bus.sol_rst_n) begin
        st_bits = 0; st_cd = 0; st_left = 0; st_idx = 0;
      end else begin
        if (st_left > 0) begin
          bus.sol_out_valid = 1'b1;
          bus.sol_out       = exp_dir(st_idx);
          st_idx++;
          st_left--;
        end else if (st_cd > 0) begin
          st_cd--;
          if (st_cd == 0) begin
            st_left = st_beats;
            st_idx  = 0;
          end
        end
        if (bus.sol_in_valid) begin
          st_bits++;
          if (st_bits == MAZE_CELLS) begin
            st_bits = 0;
            st_cd   = 3;
          end
        end
      end
    end
  end

  task automatic wait_gnt(input string tag, input logic [1:0] exp);
    int cyc;
    cyc = 0;
    do begin
      @(negedge clk);
      cyc++;
    end while (bus.gnt == '0 && cyc < 50);
    chk(tag, 32'(bus.gnt), 32'(exp));
  endtask

  // Called at the negedge where gnt is first visible; drives pre idle cycles then nbits.
  task automatic feed(input int c, input int pre, input int nbits, input string tag);
    int bad_in, bad_gnt;
    logic [1:0] oh;
    bad_in = 0; bad_gnt = 0;
    oh = 2'b01 << c;
    for (int p = 0; p < pre; p++) begin
      bus.cl_in_valid[1-c] = 1'b1;
      bus.cl_in[1-c]       = 1'b1;
      @(negedge clk);
      if (bus.sol_in_valid !== 1'b0) bad_in++;
    end
    for (int k = 0; k < nbits; k++) begin
      if (bus.gnt !== oh) bad_gnt++;
      bus.cl_in_valid[c]   = 1'b1;
      bus.cl_in[c]         = mbit(k);
      bus.cl_in_valid[1-c] = k[2];
      bus.cl_in[1-c]       = ~mbit(k);
      @(negedge clk);
      if (!(bus.sol_in_valid === 1'b1 && bus.sol_in === mbit(k))) bad_in++;
    end
    bus.cl_in_valid = '0;
    bus.cl_in       = '0;
    chk({tag, "_sol_in"}, 32'(bad_in), 0);
    chk({tag, "_gnt_hold"}, 32'(bad_gnt), 0);
    if (nbits == MAZE_CELLS) chk({tag, "_gnt_drop"}, 32'(bus.gnt), 0);
  endtask

  int c_good, c_err, c_err_at, c_first_at, c_bad_id, c_bad_dir, c_last_noerr, c_rst_low, c_tmo;

  task automatic collect(input int limit, input int exp_id);
    int cyc;
    bit done;
    c_good = 0; c_err = 0; c_err_at = -1; c_first_at = -1; c_bad_id = 0;
    c_bad_dir = 0; c_last_noerr = 0; c_rst_low = 0; c_tmo = 0;
    done = 1'b0; cyc = 0;
    while (!done && cyc < limit) begin
      @(negedge clk);
      cyc++;
      if (bus.rsp_valid) begin
        if (c_first_at < 0) c_first_at = cyc;
        if (int'(bus.rsp_id) != exp_id) c_bad_id++;
        if (bus.rsp_err) begin
          c_err++;
          c_err_at = cyc;
          if (bus.rsp_dir != 2'd0 || !bus.rsp_last) c_bad_dir++;
          done = 1'b1;
        end else begin
          if (bus.rsp_dir != exp_dir(c_good)) c_bad_dir++;
          c_good++;
          if (bus.rsp_last) begin
            c_last_noerr++;
            done = 1'b1;
          end
        end
      end
    end
    if (!done) c_tmo = 1;
    if (c_err > 0) begin
      cyc = 0;
      while (!bus.sol_rst_n && cyc < 20) begin
        c_rst_low++;
        @(negedge clk);
        cyc++;
      end
    end
  endtask

  task automatic good_job(input string tag, input int c, input int pre);
    feed(c, pre, MAZE_CELLS, tag);
    collect(400, c);
    chk({tag, "_wait"}, 32'(c_tmo), 0);
    chk({tag, "_beats"}, 32'(c_good), 32);
    chk({tag, "_last"}, 32'(c_last_noerr), 1);
    chk({tag, "_err"}, 32'(c_err), 0);
    chk({tag, "_id"}, 32'(c_bad_id), 0);
    chk({tag, "_dir"}, 32'(c_bad_dir), 0);
  endtask

  logic [11:0] outs;
  assign outs = {bus.gnt, bus.sol_rst_n, bus.sol_in_valid, bus.sol_in, bus.rsp_valid,
                 bus.rsp_dir, bus.rsp_id, bus.rsp_last, bus.rsp_err, bus.busy};

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    bus.req = '0; bus.cl_in_valid = '0; bus.cl_in = '0;
    repeat (3) @(negedge clk);
    chk("reset_outputs", 32'(outs), 0);
    rst_n = 1'b1;
    #1 chk("sol_rst_n_before_clk", 32'(bus.sol_rst_n), 0);
    @(posedge clk); #1;
    chk("sol_rst_n_after_clk", 32'(bus.sol_rst_n), 1);
    chk("busy_idle", 32'(bus.busy), 0);

    // Single job, client 0 drops req after grant.
    @(negedge clk);
    bus.req = 2'b01;
    wait_gnt("single_gnt", 2'b01);
    bus.req = '0;
    chk("single_busy", 32'(bus.busy), 1);
    feed(0, 0, MAZE_CELLS, "single");
    collect(400, 0);
    chk("single_latency", 32'(c_first_at), 6);
    chk("single_beats", 32'(c_good), 32);
    chk("single_last", 32'(c_last_noerr), 1);
    chk("single_err", 32'(c_err), 0);
    chk("single_id", 32'(c_bad_id), 0);
    chk("single_dir", 32'(c_bad_dir), 0);

    // Fairness from a fresh reset: order 0,1,0,1.
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    bus.req = 2'b11;
    for (int j = 0; j < 4; j++) begin
      wait_gnt($sformatf("fair_gnt%0d", j), 2'b01 << (j % 2));
      if (j == 3) bus.req = '0;
      good_job($sformatf("fair%0d", j), j % 2, 0);
    end

    // Feed gap on client 1 after 100 bits, then client 0 recovers cleanly.
    bus.req = 2'b10;
    wait_gnt("gap_gnt", 2'b10);
    bus.req = '0;
    feed(1, 0, 100, "gap");
    collect(10, 1);
    chk("gap_err", 32'(c_err), 1);
    chk("gap_err_within2", 32'(c_err_at >= 1 && c_err_at <= 2), 1);
    chk("gap_err_id", 32'(c_bad_id), 0);
    chk("gap_err_fields", 32'(c_bad_dir), 0);
    chk("gap_rst_low", 32'(c_rst_low), 2);
    bus.req = 2'b01;
    wait_gnt("after_gap_gnt", 2'b01);
    bus.req = '0;
    good_job("after_gap", 0, 3);

    // Solver never answers.
    st_beats = 0;
    bus.req = 2'b01;
    wait_gnt("tmo_gnt", 2'b01);
    bus.req = '0;
    feed(0, 0, MAZE_CELLS, "tmo");
    collect(TIMEOUT + 100, 0);
    chk("tmo_err", 32'(c_err), 1);
    chk("tmo_latency", 32'(c_err_at + 1), 32'(TIMEOUT + 1));
    chk("tmo_rst_low", 32'(c_rst_low), 2);

    // Over-long burst of 151 beats on client 1.
    st_beats = MAX_BEATS + 1;
    bus.req = 2'b10;
    wait_gnt("long_gnt", 2'b10);
    bus.req = '0;
    feed(1, 0, MAZE_CELLS, "long");
    collect(400, 1);
    chk("long_err", 32'(c_err), 1);
    chk("long_good_beats", 32'(c_good), 32'(MAX_BEATS - 1));
    chk("long_last_noerr", 32'(c_last_noerr), 0);
    chk("long_id", 32'(c_bad_id), 0);
    chk("long_rst_low", 32'(c_rst_low), 2);

    // Asynchronous reset in the middle of DRAIN.
    st_beats = 32;
    bus.req = 2'b01;
    wait_gnt("rst_job_gnt", 2'b01);
    bus.req = '0;
    feed(0, 0, MAZE_CELLS, "rst_job");
    begin
      int cyc;
      cyc = 0;
      do begin
        @(negedge clk);
        cyc++;
      end while (!bus.rsp_valid && cyc < 50);
      chk("rst_job_draining", 32'(bus.rsp_valid), 1);
    end
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b0;
    #1 chk("midjob_reset_outputs", 32'(outs), 0);
    @(negedge clk);
    rst_n = 1'b1;
    bus.req = 2'b11;
    #1 chk("midjob_sol_rst_n_held", 32'(bus.sol_rst_n), 0);
    @(posedge clk); #1;
    chk("midjob_sol_rst_n_release", 32'(bus.sol_rst_n), 1);
    wait_gnt("post_reset_gnt", 2'b01);
    bus.req = '0;

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule

// File: doc/maze_job_sched.md
Name: maze_job_sched

Overview:
Front-end scheduler that shares one MAZE solver instance between NUM_REQ requesting clients. It grants one client at a time, round-robin, and forwards that client's 289-bit serial maze stream to the solver. It waits for the solver's direction burst and returns the burst to the client, tagged with the client's ID. It also detects malformed streams, solver hangs and over-long bursts, and recovers from them by pulsing a solver-local reset.

Parameters:
NUM_REQ, 2, number of clients (2..4)
ID_W, 1, width of rsp_id (clog2(NUM_REQ), min 1)
MAZE_CELLS, 289, bits per maze (17x17)
TIMEOUT, 4096, max cycles allowed from the last fed bit to the first solver out_valid
MAX_BEATS, 150, max solver output beats per job
RECOVER_CYCLES, 2, cycles sol_rst_n is held low on error

Ports:
clk  in  1  clock
rst_n  in  1  reset
req  in  NUM_REQ  per-client job request (level)
gnt  out  NUM_REQ  one-hot grant, registered
cl_in_valid  in  NUM_REQ  per-client maze bit valid
cl_in  in  NUM_REQ  per-client maze bit
sol_rst_n  out  1  solver reset, active-low, registered
sol_in_valid  out  1  to solver in_valid
sol_in  out  1  to solver in
sol_out_valid  in  1  from solver out_valid
sol_out  in  2  from solver out (0 R, 1 D, 2 L, 3 U)
rsp_valid  out  1  response beat valid
rsp_dir  out  2  response direction
rsp_id  out  ID_W  client index of the current job
rsp_last  out  1  final beat of the job
rsp_err  out  1  job aborted
busy  out  1  state != IDLE

Behaviour:
- Reset is asynchronous, active-low, rst_n; the block is clocked on clk.
- Reset values: all outputs 0, including sol_rst_n (solver held in reset). sol_rst_n rises on the first clk edge after rst_n deasserts. State = IDLE. RR pointer = NUM_REQ-1, so client 0 wins first.
- All outputs are registered.
- States: IDLE, FEED, WAIT, DRAIN, RECOVER.
- IDLE:
  - req is sampled only in IDLE.
  - If any req bit is set, the winner is the first set bit searching from ptr+1 mod NUM_REQ.
  - Next cycle: gnt[winner]=1, job_id=winner, bit_cnt=0, state=FEED.
- FEED:
  - Only the granted client's cl_in_valid/cl_in are used. Non-granted clients' inputs are ignored in every state.
  - Each granted valid bit is registered to sol_in_valid/sol_in with 1-cycle latency, and bit_cnt increments.
  - Cycles before the first valid bit are idle. Once the first bit is seen, the stream must be gap-free.
  - Gap error: cl_in_valid low after the first bit and before bit MAX_CELLS... i.e. before MAZE_CELLS bits have been received. Action: drop gnt, go to RECOVER, signal error.
  - On bit MAZE_CELLS: gnt=0 next cycle, timeout counter cleared, state=WAIT. Any further bits are ignored.
- WAIT:
  - The counter increments each cycle.
  - sol_out_valid=1: go to DRAIN and capture the beat.
  - Counter reaches TIMEOUT with no sol_out_valid: go to RECOVER with error.
- DRAIN:
  - Solver beats pass through a one-entry stage, so a beat appears on rsp_* 2 cycles after it appears on sol_out.
  - rsp_last=1 on the beat whose successor cycle has sol_out_valid=0.
  - rsp_id=job_id for every beat.
  - After rsp_last: ptr=job_id, state=IDLE. The solver self-clears, so no reset pulse is issued.
  - Beat count exceeding MAX_BEATS: go to RECOVER with error.
- Error signalling (single cycle): rsp_valid=1, rsp_last=1, rsp_err=1, rsp_dir=0, rsp_id=job_id. Any partially buffered beat is discarded.
- RECOVER:
  - sol_rst_n=0 and sol_in_valid=0 for RECOVER_CYCLES cycles.
  - Then sol_rst_n=1, ptr=job_id, state=IDLE.
- The granting client's req may drop at any time without effect on the job. The job completes or errors regardless.
- sol_out_valid outside WAIT/DRAIN is ignored.
- At most one job is in flight; rsp_valid never overlaps sol_in_valid.
- Asynchronous reset mid-job: everything returns to reset values immediately. The solver is held reset until the next clk.

Test Plan:
- Single job: client 0 requests and streams 289 bits of an open maze. Required: gnt=01 for exactly the feed window; sol_in matches cl_in delayed 1 cycle; 32 beats (16 D, 16 R in solver order) out on rsp_dir with rsp_id=0; rsp_last on beat 32; rsp_err never asserted.
- Fairness: both clients hold req continuously for 4 jobs. Required: grant order 0,1,0,1; each response burst carries the matching rsp_id.
- Feed gap: client 1 drops cl_in_valid after bit 100. Required: rsp_err=1 with rsp_id=1 within 2 cycles; sol_rst_n low for 2 cycles; next job from client 0 solves correctly.
- Timeout: solver stub never raises out_valid. Required: rsp_err at TIMEOUT+1 cycles after the last fed bit, followed by the recovery pulse.
- Over-long burst: stub emits 151 beats. Required: rsp_err on beat 151; no rsp_last without rsp_err.
- Reset mid-DRAIN: required: all outputs 0 and busy=0 immediately; sol_rst_n=1 on the first clk after release; client 0 granted first afterwards.
